// File: rtl/sata_bist_lfsr_gen_if.sv
// Control/data bundle for the SATA BIST LFSR pattern generator.
// The master drives the requests and thresholds; the slave (the generator) returns its state.
interface sata_bist_lfsr_gen_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             stop;
  logic             mode;
  logic [15:0]      burst_len;
  logic             load;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] level;
  logic             pulse;
  logic [WIDTH-1:0] lfsr_out;
  logic             busy;
  logic             done;
  logic [15:0]      hit_cnt;

  modport master (
    output start, stop, mode, burst_len, load, seed, level,
    input  pulse, lfsr_out, busy, done, hit_cnt
  );

  modport slave (
    input  start, stop, mode, burst_len, load, seed, level,
    output pulse, lfsr_out, busy, done, hit_cnt
  );
endinterface

// File: rtl/sata_bist_lfsr_gen.sv
// Galois LFSR BIST pattern generator with continuous/burst sequencing and a threshold pulse.
// Latency: all outputs registered, one cycle after the controlling input; no backpressure.
module sata_bist_lfsr_gen #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(32'h000000AF),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(32'hA54455D5),
  parameter int               STEPS = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sata_bist_lfsr_gen_if.slave   if_bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_BURST = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [15:0]      r_cnt;
  logic [15:0]      r_blen;
  logic [WIDTH-1:0] r_lfsr;
  logic             r_pulse;
  logic [15:0]      r_hit_cnt;

  logic [WIDTH-1:0] w_next;
  logic             w_active;
  logic             w_ge;
  logic             w_start_ok;

  // STEPS chained Galois shifts, unrolled into one combinational advance.
  function automatic logic [WIDTH-1:0] f_advance(input logic [WIDTH-1:0] cur);
    logic [WIDTH-1:0] v;
    v = cur;
    for (int i = 0; i < STEPS; i++) begin
      v = {v[WIDTH-2:0], 1'b0} ^ (v[WIDTH-1] ? POLY : '0);
    end
    return v;
  endfunction

  assign w_next     = f_advance(r_lfsr);
  assign w_active   = (r_state == S_RUN) || (r_state == S_BURST);
  assign w_ge       = (r_lfsr >= if_bus.level);
  assign w_start_ok = (r_state == S_IDLE) && if_bus.start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
      r_blen  <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // start beats a simultaneous stop here since stop has no effect in IDLE
          if (if_bus.start) begin
            r_cnt  <= 16'd0;
            r_blen <= if_bus.burst_len;
            if (!if_bus.mode)
              r_state <= S_RUN;
            else if (if_bus.burst_len != 16'd0)
              r_state <= S_BURST;
            else
              r_state <= S_DONE;
          end
        end
        S_RUN: begin
          if (if_bus.stop)
            r_state <= S_IDLE;
        end
        S_BURST: begin
          if (if_bus.stop)
            r_state <= S_IDLE;
          else if (r_cnt == r_blen - 16'd1)
            r_state <= S_DONE;
          else
            r_cnt <= r_cnt + 16'd1;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr    <= SEED;
      r_pulse   <= 1'b0;
      r_hit_cnt <= 16'd0;
    end else begin
      // threshold uses the pre-advance / pre-load state
      r_pulse <= w_active && w_ge;

      if (w_start_ok)
        r_hit_cnt <= 16'd0;
      else if (w_active && w_ge && (r_hit_cnt != 16'hFFFF))
        r_hit_cnt <= r_hit_cnt + 16'd1;

      if (if_bus.load)
        r_lfsr <= (if_bus.seed == '0) ? SEED : if_bus.seed;
      else if (w_active)
        r_lfsr <= w_next;
    end
  end

  assign if_bus.pulse    = r_pulse;
  assign if_bus.lfsr_out = r_lfsr;
  assign if_bus.busy     = w_active;
  assign if_bus.done     = (r_state == S_DONE);
  assign if_bus.hit_cnt  = r_hit_cnt;

endmodule

// File: tb/tb_sata_bist_lfsr_gen.sv
// Scoreboard bench: stimulus pushes predicted post-edge outputs, a monitor pops and compares every cycle.
// A second instance built with STEPS=4 shares the stimulus to check multi-step advance.
module tb_sata_bist_lfsr_gen;
  localparam int          W     = 32;
  localparam logic [31:0] POLY  = 32'h000000AF;
  localparam logic [31:0] SEEDV = 32'hA54455D5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sata_bist_lfsr_gen_if #(.WIDTH(W)) bus1 ();
  sata_bist_lfsr_gen_if #(.WIDTH(W)) bus4 ();

  sata_bist_lfsr_gen #(.WIDTH(W), .STEPS(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .if_bus(bus1));
  sata_bist_lfsr_gen #(.WIDTH(W), .STEPS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .if_bus(bus4));

  typedef struct {
    logic [31:0] lfsr;
    logic        pulse;
    logic        busy;
    logic        done;
    logic [15:0] hit;
    logic [31:0] lfsr4;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: m_left = 0 idle, -1 continuous, >0 burst cycles still to run
  logic [31:0] m_lfsr  = SEEDV;
  logic [31:0] m_lfsr4 = SEEDV;
  bit          m_pulse = 1'b0;
  bit          m_done  = 1'b0;
  int          m_left  = 0;
  int          m_hit   = 0;

  function automatic logic [31:0] ref_steps(input logic [31:0] x, input int n);
    logic [31:0] v;
    v = x;
    for (int k = 0; k < n; k++) begin
      if (v >= 32'h8000_0000) v = (v << 1) ^ POLY;
      else                    v = v << 1;
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit st, input bit sp, input bit md, input int bl,
                       input bit ld, input logic [31:0] sd, input logic [31:0] lv, input bit rn);
    bit          act;
    bit          ge;
    logic [31:0] ldv;
    exp_t        e;
    @(negedge clk);
    bus1.start = st; bus1.stop = sp; bus1.mode = md; bus1.burst_len = 16'(bl);
    bus1.load  = ld; bus1.seed = sd; bus1.level = lv;
    bus4.start = st; bus4.stop = sp; bus4.mode = md; bus4.burst_len = 16'(bl);
    bus4.load  = ld; bus4.seed = sd; bus4.level = lv;
    rst_n = rn;

    if (!rn) begin
      m_lfsr = SEEDV; m_lfsr4 = SEEDV; m_pulse = 0; m_done = 0; m_left = 0; m_hit = 0;
    end else begin
      act = (m_left != 0);
      ge  = (m_lfsr >= lv);
      ldv = (sd == 32'd0) ? SEEDV : sd;
      m_pulse = act && ge;
      if (act && ge && m_hit < 65535) m_hit++;
      if (ld) begin
        m_lfsr = ldv; m_lfsr4 = ldv;
      end else if (act) begin
        m_lfsr  = ref_steps(m_lfsr, 1);
        m_lfsr4 = ref_steps(m_lfsr4, 4);
      end
      if (act) begin
        if (sp) m_left = 0;
        else if (m_left > 0) begin
          m_left--;
          if (m_left == 0) m_done = 1;
        end
      end else if (m_done) begin
        m_done = 0;
      end else if (st) begin
        m_hit = 0;
        if (!md)          m_left = -1;
        else if (bl != 0) m_left = bl;
        else              m_done = 1;
      end
    end

    e.lfsr  = m_lfsr;
    e.pulse = m_pulse;
    e.busy  = (m_left != 0);
    e.done  = m_done;
    e.hit   = 16'(m_hit);
    e.lfsr4 = m_lfsr4;
    q.push_back(e);
  endtask

  task automatic nop(input int n, input logic [31:0] lv);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 32'd0, lv, 1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("lfsr_out", 64'(bus1.lfsr_out), 64'(e.lfsr));
        chk("pulse",    64'(bus1.pulse),    64'(e.pulse));
        chk("busy",     64'(bus1.busy),     64'(e.busy));
        chk("done",     64'(bus1.done),     64'(e.done));
        chk("hit_cnt",  64'(bus1.hit_cnt),  64'(e.hit));
        chk("lfsr4",    64'(bus4.lfsr_out), 64'(e.lfsr4));
        chk("busy4",    64'(bus4.busy),     64'(e.busy));
      end
    end
  end

  initial begin : stimulus
    bit          st, sp, md, ld;
    int          bl, sel;
    logic [31:0] sd, lv;

    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 0, 32'd0, 32'd0, 0);
    nop(2, 32'd0);

    // continuous run, seed loads, unreachable threshold, stop
    cycle(1, 0, 0, 0, 0, 32'd0, 32'd0, 1);
    nop(4, 32'd0);
    cycle(0, 0, 0, 0, 1, 32'd0, 32'd0, 1);
    nop(1, 32'd0);
    cycle(0, 0, 0, 0, 1, 32'd1, 32'hFFFF_FFFF, 1);
    nop(3, 32'hFFFF_FFFF);
    cycle(0, 1, 0, 0, 0, 32'd0, 32'd0, 1);
    nop(2, 32'd0);

    // short burst, zero-length burst
    cycle(1, 0, 1, 3, 0, 32'd0, 32'd0, 1);
    nop(6, 32'd0);
    cycle(1, 0, 1, 0, 0, 32'd0, 32'd0, 1);
    nop(3, 32'd0);

    // stop at the second burst cycle
    cycle(1, 0, 1, 10, 0, 32'd0, 32'd0, 1);
    nop(1, 32'd0);
    cycle(0, 1, 0, 0, 0, 32'd0, 32'd0, 1);
    nop(3, 32'd0);

    // reset mid-burst, then stay idle with no new start
    cycle(1, 0, 1, 10, 0, 32'd0, 32'd0, 1);
    nop(2, 32'd0);
    cycle(0, 0, 0, 0, 0, 32'd0, 32'd0, 0);
    nop(4, 32'd0);

    // start and stop together in IDLE: start wins; a start while running is ignored
    cycle(1, 1, 0, 0, 0, 32'd0, 32'h8000_0000, 1);
    nop(3, 32'h8000_0000);
    cycle(1, 0, 1, 2, 0, 32'd0, 32'h8000_0000, 1);
    nop(2, 32'h8000_0000);
    cycle(0, 1, 0, 0, 0, 32'd0, 32'd0, 1);
    nop(1, 32'd0);

    for (int k = 0; k < 600; k++) begin
      st  = ($urandom % 8) == 0;
      sp  = ($urandom % 16) == 0;
      md  = 1'($urandom % 2);
      bl  = $urandom_range(0, 12);
      ld  = ($urandom % 12) == 0;
      sd  = (($urandom % 3) == 0) ? 32'd0 : $urandom;
      sel = $urandom_range(0, 3);
      lv  = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFF_FFFF : $urandom;
      cycle(st, sp, md, bl, ld, sd, lv, ($urandom % 150) != 0);
    end
    nop(2, 32'd0);

    @(posedge clk);
    #2;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sata_bist_lfsr_gen.md
SATA_BIST_LFSR_GEN -- requirements
Module: sata_bist_lfsr_gen

Interface
REQ-001 Parameter WIDTH, default 32, LFSR width in bits (legal 8..64).
REQ-002 Parameter POLY, default 32'h000000AF, Galois feedback taps (bit i set = XOR feedback into bit i), x^WIDTH term implicit.
REQ-003 Parameter SEED, default 32'hA54455D5, reset value and zero-seed substitute (nonzero).
REQ-004 Parameter STEPS, default 1, LFSR shifts applied per advance cycle (legal 1..WIDTH).
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  one-cycle request to begin generation; honoured only in IDLE.
REQ-008 stop  in  1  abort RUN/BURST back to IDLE.
REQ-009 mode  in  1  sampled with start: 0 = continuous, 1 = burst.
REQ-010 burst_len  in  16  advance cycles per burst, sampled with start.
REQ-011 load  in  1  load seed into LFSR this cycle.
REQ-012 seed  in  WIDTH  value loaded on load.
REQ-013 level  in  WIDTH  unsigned pulse threshold.
REQ-014 pulse  out  1  registered threshold output.
REQ-015 lfsr_out  out  WIDTH  current LFSR state.
REQ-016 busy  out  1  high in RUN or BURST.
REQ-017 done  out  1  one-cycle burst-complete strobe.
REQ-018 hit_cnt  out  16  count of active cycles with pulse computed high.

Function
REQ-019 One step: next = {cur[WIDTH-2:0],1'b0} XOR (cur[WIDTH-1] ? POLY : 0); advance applies STEPS chained steps combinationally.
REQ-020 FSM states IDLE, RUN, BURST, DONE; registered state.
REQ-021 IDLE: start & mode=0 -> RUN; start & mode=1 & burst_len!=0 -> BURST; start & mode=1 & burst_len==0 -> DONE.
REQ-022 RUN: stays until stop -> IDLE.
REQ-023 BURST: internal counter cnt cleared on entry, increments per advance cycle; when cnt==burst_len_q-1 -> DONE; stop -> IDLE without done.
REQ-024 DONE: done=1 for exactly that cycle, then IDLE unconditionally.
REQ-025 Active cycle = state RUN or BURST: lfsr <= advance(lfsr); pulse <= (lfsr >= level) using pre-advance lfsr, visible next cycle.
REQ-026 IDLE/DONE: lfsr holds, pulse <= 0.
REQ-027 load in any state: lfsr <= (seed==0 ? SEED : seed); overrides advance that cycle; FSM and cnt unaffected; pulse still computed from pre-load lfsr if active.
REQ-028 hit_cnt cleared on accepted start; +1 each active cycle where (lfsr >= level); saturates at 16'hFFFF.
REQ-029 start outside IDLE ignored; stop in IDLE/DONE ignored; stop and start same cycle in IDLE: start wins.
REQ-030 busy and done are decoded from registered state (no combinational path from inputs).

Reset
REQ-031 On rst_n low, asynchronously: lfsr=SEED, state=IDLE, pulse=0, busy=0, done=0, hit_cnt=0, cnt=0.
REQ-032 Reset mid-burst aborts with no done strobe; operation resumes only on a new start after release.

Verification
REQ-033 Reset, defaults -> lfsr_out=32'hA54455D5, pulse=0, busy=0, hit_cnt=0.
REQ-034 start mode=0, level=0 -> busy next cycle; lfsr_out 32'h4A88AB05 then 32'h9511560A; pulse=1 from second active cycle onward.
REQ-035 start mode=1, burst_len=3, level=0 -> busy 3 cycles, done 1 cycle, hit_cnt=3, then IDLE with lfsr held.
REQ-036 load with seed=0 during RUN -> lfsr_out=32'hA54455D5 next cycle; seed=32'h1 -> lfsr_out=32'h1; level=32'hFFFFFFFF -> pulse stays 0.
REQ-037 burst_len=0 -> done one cycle after start, busy never high, lfsr unchanged.
REQ-038 stop mid-burst (cycle 2 of 10) and rst_n low mid-burst -> IDLE, no done pulse; STEPS=4 build: one active cycle equals four single steps.
